led_column_shifter: RTL
=======================

Name: led_column_shifter

Overview:
Downstream stage of the LED matrix scanner. Accepts one row of parallel R/G/B column data plus a row index per transfer, and shifts the data out serially to the 74HC595-style column driver chain. It then blanks the display, pulses the latch, switches the row index, and unblanks. Sits between the scanner and the physical column/row driver pins.

Parameters:
COLS, 8, columns per row; each colour bus is COLS bits wide; 3*COLS bits are shifted per row.
CLK_DIV, 2, clk cycles per ser_clk half-period; must be >= 1.
BLANK_CYCLES, 2, clk cycles oe_n is held high before latch; must be >= 1.
LATCH_CYCLES, 2, clk cycles latch is held high; must be >= 1.

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  row data and row_in valid
load_ready  out  1  block idle and able to accept a row
data_r  in  COLS  red column bits
data_g  in  COLS  green column bits
data_b  in  COLS  blue column bits
row_in  in  3  row index belonging to this data
ser_out  out  1  serial data to column chain
ser_clk  out  1  shift clock to column chain
latch  out  1  storage-register latch pulse
oe_n  out  1  active-low output enable (1 = display blanked)
row_out  out  3  row index driven to the row decoder
done  out  1  one-cycle pulse when a row transfer has fully completed

Behaviour:
- Reset (async, rst_n=0): state IDLE; ser_out=0, ser_clk=0, latch=0, oe_n=1, row_out=0, done=0, load_ready=1. oe_n remains 1 until the first transfer has latched.
- All outputs are registered. Counter widths are sized with $clog2 of their maximum.
- FSM states: IDLE, SHIFT, BLANK, LATCH.
- IDLE: load_ready=1. A handshake occurs at edge T when load_valid=1 and load_ready=1.
  - At T: capture shift word {data_r, data_g, data_b} (MSB first) and capture row_in.
  - From T+1: state is SHIFT and load_ready=0.
- SHIFT: 3*COLS bits, MSB first; the first bit is data_r[COLS-1] and the last is data_b[0].
  - Each bit spends CLK_DIV cycles with ser_clk=0 (ser_out already stable for that bit), then CLK_DIV cycles with ser_clk=1.
  - ser_out changes only on the cycle ser_clk returns to 0.
  - Duration: 3*COLS*2*CLK_DIV cycles. After the last high phase, ser_clk=0 and the FSM goes to BLANK.
  - oe_n is unchanged during SHIFT; the previous row stays displayed.
- BLANK: oe_n=1 for BLANK_CYCLES; ser_clk=0; ser_out holds the last bit.
- LATCH:
  - latch=1 and oe_n=1 for LATCH_CYCLES.
  - row_out is loaded with the captured row on the first LATCH cycle.
  - Next state is IDLE.
- IDLE entry after LATCH: latch=0, oe_n=0, done=1 for exactly that one cycle, load_ready=1. Back-to-back loads are accepted on that same cycle.
- Default timing (COLS=8, CLK_DIV=2, BLANK=2, LATCH=2), with handshake at T:
  - T+1..T+96: SHIFT.
  - T+97..T+98: BLANK.
  - T+99..T+100: LATCH.
  - T+101: IDLE with done=1. Total period 101 cycles per row.
- load_valid while load_ready=0 is ignored; no queuing, and inputs are not sampled.
- Input changes after the handshake have no effect on the transfer in progress.
- rst_n asserted mid-transfer aborts immediately to reset values. A partially shifted chain is never latched.
- Simultaneous reset release and load_valid: the load is accepted only on an edge where rst_n is already high.

Test Plan:
1. Reset, then load r=8'hA5 g=8'h3C b=8'h0F row_in=3 -> 24 rising ser_clk edges sample ser_out = A5,3C,0F MSB-first; each ser_clk high/low phase lasts 2 cycles; latch high for cycles T+99..T+100; row_out=3 from T+99; done pulse at T+101; oe_n=0 from T+101.
2. Assert load_valid continuously with rows 0..7 -> handshakes exactly 101 cycles apart; row_out steps 0..7; oe_n high only during BLANK+LATCH (4 cycles per row).
3. Change data_* and toggle load_valid during SHIFT -> serial stream equals the captured data; no extra handshake occurs.
4. Deassert rst_n at T+40 -> all outputs return to reset values asynchronously; latch never pulses; load_ready=1 after release.
5. Parameter sweep COLS=4, CLK_DIV=1, BLANK=1, LATCH=3 -> 12 bits, ser_clk period 2 cycles, done at T+1+24+1+3.
6. Load all-ones then all-zeros -> ser_out constant 1 then 0 across full transfers; ser_out stable at every ser_clk rising edge (checker assertion).

Source files
------------

// File: rtl/led_column_shifter.sv
// led_column_shifter: serialises one row of RGB column data into a
// 74HC595-style chain, then blanks, latches and switches the row.
module led_column_shifter #(
  parameter int COLS         = 8,
  parameter int CLK_DIV      = 2,
  parameter int BLANK_CYCLES = 2,
  parameter int LATCH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [COLS-1:0] data_r,
  input  logic [COLS-1:0] data_g,
  input  logic [COLS-1:0] data_b,
  input  logic [2:0]      row_in,
  output logic            ser_out,
  output logic            ser_clk,
  output logic            latch,
  output logic            oe_n,
  output logic [2:0]      row_out,
  output logic            done
);

  localparam int W    = 3 * COLS;
  localparam int M1   = (CLK_DIV > BLANK_CYCLES) ?
                        CLK_DIV : BLANK_CYCLES;
  localparam int MAXC = (M1 > LATCH_CYCLES) ?
                        M1 : LATCH_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BW   = (W > 1) ? $clog2(W) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_BLANK,
    S_LATCH
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [2:0]     row_q, row_d;
  logic           ser_out_d, ser_clk_d, latch_d;
  logic           oe_n_d, done_d, ready_d;
  logic [2:0]     row_out_d;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    row_d     = row_q;
    ser_out_d = ser_out;
    ser_clk_d = ser_clk;
    latch_d   = latch;
    oe_n_d    = oe_n;
    row_out_d = row_out;
    done_d    = 1'b0;
    ready_d   = load_ready;
    unique case (state_q)
      S_IDLE: begin
        if (load_valid && load_ready) begin
          state_d   = S_SHIFT;
          sh_d      = {data_r, data_g, data_b};
          ser_out_d = data_r[COLS-1];
          ser_clk_d = 1'b0;
          cnt_d     = '0;
          bit_d     = '0;
          row_d     = row_in;
          ready_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!ser_clk) begin
            ser_clk_d = 1'b1;
          end else begin
            ser_clk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = S_BLANK;
              oe_n_d  = 1'b1;
            end else begin
              bit_d     = bit_q + 1'b1;
              sh_d      = sh_q << 1;
              ser_out_d = sh_q[W-2];
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLK_LAST) begin
          cnt_d     = '0;
          state_d   = S_LATCH;
          latch_d   = 1'b1;
          row_out_d = row_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          latch_d = 1'b0;
          oe_n_d  = 1'b0;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers; reset blanks the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      row_q      <= '0;
      ser_out    <= 1'b0;
      ser_clk    <= 1'b0;
      latch      <= 1'b0;
      oe_n       <= 1'b1;
      row_out    <= '0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      row_q      <= row_d;
      ser_out    <= ser_out_d;
      ser_clk    <= ser_clk_d;
      latch      <= latch_d;
      oe_n       <= oe_n_d;
      row_out    <= row_out_d;
      done       <= done_d;
      load_ready <= ready_d;
    end
  end

endmodule
